// File: rtl/qcl_brd_link_sched.sv
// qcl_brd_link_sched: round-robin burst scheduler for one outbound board link.
//
// Ports:
//   clk_i       - clock
//   reset_i     - asynchronous active-low reset
//   v_i         - per-requester flit valid          [els_p]
//   data_i      - per-requester flits, requester i at bits [i*data_width_p +: data_width_p]
//   last_i      - per-requester end-of-packet marker [els_p]
//   ready_o     - per-requester flit accept          [els_p]
//   v_o/data_o  - link flit valid / data
//   last_o      - link end-of-burst marker
//   ready_i     - link accept
//   grant_id_o  - current grantee, held while idle
//   busy_o      - high while a burst is in progress
//   timeout_o   - one-cycle pulse when a stalled burst is aborted
//
// Optional feature: define QCL_BRD_SCHED_TIMEOUT_EN to build the stall
// counter that aborts a burst after timeout_p cycles without a valid flit.
// Without it, timeout_o is tied low and a stalled grantee keeps the link.
module qcl_brd_link_sched #(
    parameter int els_p        = 4,
    parameter int data_width_p = 32,
    parameter int max_burst_p  = 8,
    parameter int timeout_p    = 255,
    localparam int id_w_lp     = $clog2(els_p),
    localparam int cnt_w_lp    = $clog2(max_burst_p) + 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [els_p-1:0]                v_i,
    input  logic [els_p*data_width_p-1:0]   data_i,
    input  logic [els_p-1:0]                last_i,
    output logic [els_p-1:0]                ready_o,
    output logic                            v_o,
    output logic [data_width_p-1:0]         data_o,
    output logic                            last_o,
    input  logic                            ready_i,
    output logic [id_w_lp-1:0]              grant_id_o,
    output logic                            busy_o,
    output logic                            timeout_o
);

    if (els_p < 2 || els_p > 16 || max_burst_p < 1 || max_burst_p > 256 || timeout_p < 1) begin : g_bad_param
        $error("qcl_brd_link_sched: parameter out of legal range");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [id_w_lp-1:0]  rr_ptr_q, rr_ptr_d;
    logic [id_w_lp-1:0]  grant_q, grant_d;
    logic [cnt_w_lp-1:0] beat_cnt_q, beat_cnt_d;
    logic [id_w_lp-1:0]  sel, idx;
    logic                found;
    logic                beat;

    logic [data_width_p-1:0] data_a [els_p];

    for (genvar i = 0; i < els_p; i++) begin : g_unpack
        assign data_a[i] = data_i[i*data_width_p +: data_width_p];
    end

    // Round-robin search starting just after the last grantee.
    always_comb begin
        found = 1'b0;
        sel   = grant_q;
        idx   = '0;
        for (int i = 1; i <= els_p; i++) begin
            idx = id_w_lp'((int'(rr_ptr_q) + i) % els_p);
            if (!found && v_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign busy_o     = (state_q == BURST);
    assign v_o        = busy_o & v_i[grant_q];
    assign data_o     = busy_o ? data_a[grant_q] : '0;
    assign last_o     = v_o & (last_i[grant_q] | (beat_cnt_q == cnt_w_lp'(max_burst_p - 1)));
    assign grant_id_o = grant_q;
    assign beat       = v_o & ready_i;

    always_comb begin
        ready_o = '0;
        if (busy_o) ready_o[grant_q] = ready_i;
    end

`ifdef QCL_BRD_SCHED_TIMEOUT_EN
    localparam int st_w_lp = $clog2(timeout_p + 1);
    logic [st_w_lp-1:0] stall_q, stall_d;
    logic               timeout_q, timeout_d;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
`ifdef QCL_BRD_SCHED_TIMEOUT_EN
        stall_d    = stall_q;
        timeout_d  = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (found) begin
                grant_d    = sel;
                beat_cnt_d = '0;
                state_d    = BURST;
`ifdef QCL_BRD_SCHED_TIMEOUT_EN
                stall_d    = '0;
`endif
            end
        end else begin
            if (beat) begin
                // The final beat is never counted, so beat_cnt stops at max_burst_p-1.
                if (last_o) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
`ifdef QCL_BRD_SCHED_TIMEOUT_EN
            if (beat) begin
                stall_d = '0;
            end else if (!v_i[grant_q]) begin
                stall_d = stall_q + 1'b1;
                // This stall cycle brings the count to timeout_p.
                if (stall_q == st_w_lp'(timeout_p - 1)) begin
                    state_d   = IDLE;
                    rr_ptr_d  = grant_q;
                    timeout_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= id_w_lp'(els_p - 1);
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef QCL_BRD_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_qcl_brd_link_sched.sv
// tb_qcl_brd_link_sched: scoreboard bench for the board link scheduler.
module tb_qcl_brd_link_sched;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk_i   = 1'b0;
    logic           reset_i = 1'b1;
    logic [N-1:0]   v_i     = '0;
    logic [N-1:0]   last_i  = '0;
    logic [N*W-1:0] data_i  = '0;
    logic           ready_i = 1'b0;
    logic [N-1:0]   ready_o;
    logic           v_o, last_o, busy_o, timeout_o;
    logic [W-1:0]   data_o;
    logic [1:0]     grant_id_o;

    typedef struct {
        int          cyc;
        logic [1:0]  g;
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    rem[N];
    int    seq[N];
    bit    uselast[N];
    bit    mask[N];

    logic        o_v, o_l, o_b, o_t, o_rdy;
    logic [31:0] o_d;
    logic [1:0]  o_g;
    logic [3:0]  o_r;

    qcl_brd_link_sched #(
        .els_p(N), .data_width_p(W), .max_burst_p(8), .timeout_p(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .last_i(last_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
        .last_o(last_o), .ready_i(ready_i), .grant_id_o(grant_id_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] fdat(int i, int s);
        return 32'(i * 65536 + s) ^ 32'hA500_0000;
    endfunction

    task automatic push_beat(int cyc, int g, int s, bit l);
        beat_t e;
        e.cyc = cyc;
        e.g   = 2'(g);
        e.d   = fdat(g, s);
        e.l   = l;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            v_i[i]            = (rem[i] > 0) && !mask[i];
            data_i[i*W +: W]  = fdat(i, seq[i]);
            last_i[i]         = uselast[i] && (rem[i] == 1);
        end
    endtask

    task automatic tick();
        drive();
        #1;
        o_v = v_o; o_d = data_o; o_l = last_o; o_g = grant_id_o;
        o_b = busy_o; o_r = ready_o; o_t = timeout_o; o_rdy = ready_i;
        for (int i = 0; i < N; i++)
            if (v_i[i] && ready_o[i]) begin
                rem[i]--;
                seq[i]++;
            end
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; seq[i] = 0; uselast[i] = 0; mask[i] = 0;
        end
        sb.delete();
    endtask

    task automatic do_reset();
        clear_model();
        drive();
        ready_i = 1'b1;
        reset_i = 1'b0;
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        clear_model();
        for (int i = 0; i < N; i++) rem[i] = 3;
        drive();
        ready_i = 1'b1;
        #2;
        reset_i = 1'b0;
        @(posedge clk_i);
        #2;
        vectors++;
        if (v_o !== 1'b0 || ready_o !== 4'b0 || last_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_link got v=%b r=%b l=%b exp 0 0000 0", v_o, ready_o, last_o);
        end
        vectors++;
        if (busy_o !== 1'b0 || grant_id_o !== 2'd0 || timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b g=%0d to=%b exp 0 0 0", busy_o, grant_id_o, timeout_o);
        end
        reset_i = 1'b1;
        tick();
        vectors++;
        if (o_b !== 1'b0 || o_v !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_arb_latency got busy=%b v=%b exp 0 0", o_b, o_v);
        end
        tick();
        vectors++;
        if (o_g !== 2'd0 || o_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_grant got g=%0d busy=%b exp 0 1", o_g, o_b);
        end
    endtask

    task automatic test_rr_basic();
        do_reset();
        rem[1] = 3; rem[2] = 3; uselast[1] = 1; uselast[2] = 1;
        for (int k = 0; k < 3; k++) push_beat(1 + k, 1, k, k == 2);
        for (int k = 0; k < 3; k++) push_beat(5 + k, 2, k, k == 2);
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            tick();
            if (o_v && o_rdy) begin
                beat_t e;
                e = sb.pop_front();
                vectors++;
                if (c !== e.cyc || o_g !== e.g || o_d !== e.d || o_l !== e.l || o_r !== (4'b1 << e.g)) begin
                    miscompares++;
                    $display("FAIL rr_beat got cyc=%0d g=%0d d=%h l=%b r=%b exp cyc=%0d g=%0d d=%h l=%b",
                             c, o_g, o_d, o_l, o_r, e.cyc, e.g, e.d, e.l);
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rr_drain got %0d beats outstanding exp 0", sb.size());
        end
    endtask

    task automatic test_max_burst();
        do_reset();
        rem[0] = 20;
        for (int k = 0; k < 20; k++) push_beat(1 + k + k / 8, 0, k, (k % 8) == 7);
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            tick();
            if (o_v && o_rdy) begin
                beat_t e;
                e = sb.pop_front();
                vectors++;
                if (c !== e.cyc || o_g !== e.g || o_d !== e.d || o_l !== e.l) begin
                    miscompares++;
                    $display("FAIL burst_beat got cyc=%0d g=%0d d=%h l=%b exp cyc=%0d g=%0d d=%h l=%b",
                             c, o_g, o_d, o_l, e.cyc, e.g, e.d, e.l);
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL burst_drain got %0d beats outstanding exp 0", sb.size());
        end
    endtask

    task automatic test_ready_toggle();
        int rdy_cyc[8] = '{1, 3, 5, 7, 9, 10, 11, 12};
        do_reset();
        rem[3] = 10;
        for (int k = 0; k < 8; k++) push_beat(rdy_cyc[k], 3, k, k == 7);
        push_beat(14, 0, 0, 0);
        for (int c = 0; c < 15; c++) begin
            if (c == 1) begin
                rem[0] = 5; rem[1] = 5; rem[2] = 5;
            end
            ready_i = (c >= 1 && c <= 8) ? 1'(c % 2) : 1'b1;
            tick();
            if (c >= 1 && c <= 12) begin
                vectors++;
                if (o_r !== {o_rdy, 3'b000} || o_v !== 1'b1 || o_g !== 2'd3) begin
                    miscompares++;
                    $display("FAIL toggle_hold c=%0d got r=%b v=%b g=%0d exp r=%b v=1 g=3",
                             c, o_r, o_v, o_g, {o_rdy, 3'b000});
                end
            end
            if (o_v && o_rdy && sb.size() > 0) begin
                beat_t e;
                e = sb.pop_front();
                vectors++;
                if (c !== e.cyc || o_g !== e.g || o_d !== e.d || o_l !== e.l) begin
                    miscompares++;
                    $display("FAIL toggle_beat got cyc=%0d g=%0d d=%h l=%b exp cyc=%0d g=%0d d=%h l=%b",
                             c, o_g, o_d, o_l, e.cyc, e.g, e.d, e.l);
                end
            end
        end
        vectors++;
        if (sb.size() != 0 || o_g !== 2'd0 || o_b !== 1'b1) begin
            miscompares++;
            $display("FAIL toggle_next got left=%0d g=%0d busy=%b exp 0 0 1", sb.size(), o_g, o_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rem[2] = 5;
        tick();
        tick();
        drive();
        #1;
        vectors++;
        if (v_o !== 1'b1 || grant_id_o !== 2'd2 || data_o !== fdat(2, 1)) begin
            miscompares++;
            $display("FAIL mid_pre got v=%b g=%0d d=%h exp 1 2 %h", v_o, grant_id_o, data_o, fdat(2, 1));
        end
        reset_i = 1'b0;
        #1;
        vectors++;
        if (v_o !== 1'b0 || ready_o !== 4'b0 || last_o !== 1'b0 || busy_o !== 1'b0 || grant_id_o !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_reset got v=%b r=%b l=%b busy=%b g=%0d exp all 0",
                     v_o, ready_o, last_o, busy_o, grant_id_o);
        end
        clear_model();
        for (int i = 0; i < N; i++) rem[i] = 5;
        drive();
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        tick();
        tick();
        vectors++;
        if (o_g !== 2'd0 || o_b !== 1'b1 || o_v !== 1'b1 || o_d !== fdat(0, 0)) begin
            miscompares++;
            $display("FAIL mid_regrant got g=%0d busy=%b v=%b d=%h exp 0 1 1 %h", o_g, o_b, o_v, o_d, fdat(0, 0));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        rem[1] = 10; rem[2] = 3;
        tick();
        tick();
        vectors++;
        if (o_v !== 1'b1 || o_g !== 2'd1 || o_d !== fdat(1, 0)) begin
            miscompares++;
            $display("FAIL stall_first got v=%b g=%0d d=%h exp 1 1 %h", o_v, o_g, o_d, fdat(1, 0));
        end
        mask[1] = 1;
`ifdef QCL_BRD_SCHED_TIMEOUT_EN
        for (int c = 2; c <= 5; c++) begin
            tick();
            vectors++;
            if (o_t !== 1'b0 || o_b !== 1'b1 || o_v !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_wait c=%0d got to=%b busy=%b v=%b exp 0 1 0", c, o_t, o_b, o_v);
            end
        end
        tick();
        vectors++;
        if (o_t !== 1'b1 || o_b !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_pulse got to=%b busy=%b exp 1 0", o_t, o_b);
        end
        tick();
        vectors++;
        if (o_t !== 1'b0 || o_g !== 2'd2 || o_b !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_next got to=%b g=%0d busy=%b exp 0 2 1", o_t, o_g, o_b);
        end
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            vectors++;
            if (o_t !== 1'b0 || o_g !== 2'd1 || o_b !== 1'b1 || o_v !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold c=%0d got to=%b g=%0d busy=%b v=%b exp 0 1 1 0", c, o_t, o_g, o_b, o_v);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rr_basic();
        test_max_burst();
        test_ready_toggle();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
